// File: rtl/conv_pkg.sv
// Shared constants and the int8 saturation helper for the conv post-processing blocks.
package conv_pkg;

  localparam int unsigned ACC_W  = 20;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned Q_W    = 8;
  localparam int unsigned LANES  = 4;
  localparam int          QMAX   = 127;
  localparam int          QMIN   = -128;

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned RND_W  = ACC_W + 2;
  localparam int unsigned WORD_W = Q_W * LANES;

  // Optional ReLU followed by clamp to [QMIN, QMAX].
  function automatic logic [Q_W-1:0] sat_q8(input logic signed [RND_W-1:0] v, input logic relu);
    logic [Q_W-1:0] q;
    if (relu && (int'(v) < 0)) q = '0;
    else if (int'(v) > QMAX)   q = Q_W'(QMAX);
    else if (int'(v) < QMIN)   q = Q_W'(QMIN);
    else                       q = Q_W'(v);
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head entry is visible whenever not empty.
module sync_fifo_fwft #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iData,
  input  logic                     iPop,
  output logic [WIDTH-1:0]         oHead,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      count;
  logic             wrEn, rdEn;

  assign oEmpty = (count == '0);
  assign oFull  = (count == (AW+1)'(DEPTH));
  assign oCount = count;
  assign oHead  = mem[rdPtr];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign rdEn = iPop & ~oEmpty;
  assign wrEn = iPush & (~oFull | rdEn);

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= iData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_post_quant.sv
// Bias add, round/shift, ReLU and int8 saturation on four MAC lanes, buffered
// in a FWFT FIFO with frame-end tagging and sticky overflow.
module conv_post_quant
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned CW        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [ACC_W-1:0]  iAcc0,
  input  logic [ACC_W-1:0]  iAcc1,
  input  logic [ACC_W-1:0]  iAcc2,
  input  logic [ACC_W-1:0]  iAcc3,
  input  logic [BIAS_W-1:0] iBias,
  input  logic [4:0]        iShift,
  input  logic              iRelu,
  input  logic              iRdy,
  input  logic              iClrOvf,
  output logic              oVld,
  output logic [WORD_W-1:0] oData,
  output logic              oLast,
  output logic              oAfull,
  output logic              oOvf
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [SUM_W-1:0] s1Sum [LANES];
  logic signed [RND_W-1:0] s2R [LANES];
  logic                    s1Vld, s1Relu, s2Vld, s2Relu;
  logic [4:0]              s1Shift;

  logic [WORD_W-1:0] pushData, holdData;
  logic [WORD_W:0]   fHead;
  logic              fFull, fEmpty, pop, accept, drop, lastTag;
  logic [CNT_W-1:0]  fCount;
  logic [CW-1:0]     frameCnt;

  assign acc[0] = iAcc0;
  assign acc[1] = iAcc1;
  assign acc[2] = iAcc2;
  assign acc[3] = iAcc3;

  // Per-stage control travels with the data so parameters may change per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Vld   <= 1'b0;
      s1Relu  <= 1'b0;
      s1Shift <= '0;
      s2Vld   <= 1'b0;
      s2Relu  <= 1'b0;
    end else begin
      s1Vld <= vld_i;
      s2Vld <= s1Vld;
      if (vld_i) begin
        s1Relu  <= iRelu;
        s1Shift <= (iShift > 5'd20) ? 5'd20 : iShift;
      end
      if (s1Vld) s2Relu <= s1Relu;
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : gLane
    logic signed [RND_W-1:0] ext, rnd, tmp, rVal;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) s1Sum[g] <= '0;
      else if (vld_i) s1Sum[g] <= SUM_W'(acc[g]) + SUM_W'($signed(iBias));
    end

    // Round half toward +inf, then arithmetic shift.
    always_comb begin
      ext = RND_W'(s1Sum[g]);
      rnd = '0;
      if (s1Shift != 5'd0) rnd = RND_W'(1) <<< (s1Shift - 5'd1);
      tmp  = ext + rnd;
      rVal = tmp >>> s1Shift;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) s2R[g] <= '0;
      else if (s1Vld) s2R[g] <= rVal;
    end

    assign pushData[g*Q_W +: Q_W] = sat_q8(s2R[g], s2Relu);
  end

  assign pop     = ~fEmpty & iRdy;
  assign accept  = s2Vld & (~fFull | pop);
  assign drop    = s2Vld & fFull & ~pop;
  assign lastTag = (frameCnt == CW'(NUM_WORDS - 1));

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W + 1)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .iPush  (s2Vld),
    .iData  ({lastTag, pushData}),
    .iPop   (pop),
    .oHead  (fHead),
    .oFull  (fFull),
    .oEmpty (fEmpty),
    .oCount (fCount)
  );

  // Frame index advances only on words actually stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCnt <= '0;
      holdData <= '0;
      oOvf     <= 1'b0;
    end else begin
      if (accept) frameCnt <= lastTag ? '0 : frameCnt + CW'(1);
      if (pop) holdData <= fHead[WORD_W-1:0];
      if (drop) oOvf <= 1'b1;
      else if (iClrOvf) oOvf <= 1'b0;
    end
  end

  assign oVld   = ~fEmpty;
  assign oData  = fEmpty ? holdData : fHead[WORD_W-1:0];
  assign oLast  = ~fEmpty & fHead[WORD_W];
  assign oAfull = (fCount >= CNT_W'(DEPTH - 3));

endmodule
